mem_stage_lsu: RTL and testbench

Load/store unit for the MEM stage of the 5-stage RISC-V core. It is driven from the EX/MEM pipeline register (address, store data, func3, read/write strobes) and talks to a word-organised, variable-latency data memory over a req/ack handshake. It generates byte enables and lane-replicated store data, and extracts and sign/zero-extends load data. It stalls the pipeline until the access completes and flags misaligned or illegal accesses without touching memory.

---
 rtl/mem_stage_lsu_pkg.sv | 39 +++
 rtl/mem_stage_lsu_align.sv | 65 ++++++
 rtl/mem_stage_lsu.sv | 137 +++++++++++++
 tb/tb_mem_stage_lsu.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared pipeline definitions for the MEM-stage load/store unit:
// func3 encodings, FSM state type and the access legality check.
package mem_stage_lsu_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} lsu_state_t;

  // True when the access is naturally aligned and func3 is valid for its direction.
  function automatic logic lsu_legal(input logic we, input logic [2:0] f3,
                                     input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    if (we) begin
      case (f3)
        F3_B:    ok = 1'b1;
        F3_H:    ok = !lo[0];
        F3_W:    ok = (lo == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_B, F3_BU: ok = 1'b1;
        F3_H, F3_HU: ok = !lo[0];
        F3_W:        ok = (lo == 2'b00);
        default:     ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: byte enables and replicated store data for the
// outgoing access, and byte/half selection with sign/zero extension for loads.
module lsu_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]           st_lo,
  input  logic [1:0]           st_size,
  input  logic [DATA_W-1:0]    st_data,
  output logic [NUM_LANES-1:0] st_be,
  output logic [DATA_W-1:0]    st_wdata,
  input  logic [1:0]           ld_lo,
  input  logic [2:0]           ld_func3,
  input  logic [DATA_W-1:0]    ld_word,
  output logic [DATA_W-1:0]    ld_data
);

  // Per byte lane: enable and source byte, chosen by access size.
  // Size comes from func3[1:0] so unsigned loads get the same enables as signed ones.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic             be_g;
    logic [LANE_W-1:0] wd_g;

    // Lane enable and replicated data for this byte position
    always_comb begin
      be_g = 1'b0;
      wd_g = st_data[LANE_W*g +: LANE_W];
      case (st_size)
        2'd0: begin
          be_g = (st_lo == 2'(g));
          wd_g = st_data[LANE_W-1:0];
        end
        2'd1: begin
          be_g = (st_lo[1] == 1'(g / 2));
          wd_g = st_data[LANE_W*(g % 2) +: LANE_W];
        end
        2'd2: be_g = 1'b1;
        default: be_g = 1'b0;
      endcase
    end

    assign st_be[g]                      = be_g;
    assign st_wdata[LANE_W*g +: LANE_W] = wd_g;
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = ld_word[{ld_lo, 3'b000} +: 8];
  assign ld_half = ld_lo[1] ? ld_word[DATA_W-1:16] : ld_word[15:0];

  // Extend the selected byte/half according to func3; words pass through
  always_comb begin
    ld_data = ld_word;
    case (ld_func3)
      F3_B:    ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
      F3_H:    ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {{(DATA_W-16){1'b0}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: accepts one access from EX/MEM, issues it to a
// variable-latency word memory over req/ack, stalls the pipeline until the
// response, and rejects misaligned/illegal accesses without touching memory.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_func3,
  output logic                  stall,
  output logic                  ld_valid,
  output logic [DATA_W-1:0]     ld_data,
  output logic                  acc_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DM_ADDRESS-3:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [CNT_W-1:0]      wait_cnt
);

  lsu_state_t state, state_nxt;

  logic                 req_any;
  logic                 req_legal;
  logic                 accept;
  logic                 done;
  logic [1:0]           lat_lo;
  logic [2:0]           lat_func3;
  logic [3:0]           st_be;
  logic [DATA_W-1:0]    st_wdata;
  logic [DATA_W-1:0]    ld_ext;

  // A simultaneous read and write is treated as a write.
  assign req_any   = req_read | req_write;
  assign req_legal = lsu_legal(req_write, req_func3, req_addr[1:0]);
  assign accept    = (state == IDLE) && req_any && req_legal;
  assign done      = (state == BUSY) && mem_ack;

  // Store lanes come from the live request (registered at acceptance);
  // load extraction uses the latched request against the returning word.
  lsu_align #(.DATA_W(DATA_W)) u_align (
    .st_lo    (req_addr[1:0]),
    .st_size  (req_func3[1:0]),
    .st_data  (req_wdata),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_lo    (lat_lo),
    .ld_func3 (lat_func3),
    .ld_word  (mem_rdata),
    .ld_data  (ld_ext)
  );

  // Next state, stall, error and load-valid decode
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    acc_err   = 1'b0;
    ld_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          if (req_legal) begin
            stall     = 1'b1;
            state_nxt = BUSY;
          end else begin
            acc_err = 1'b1;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack) state_nxt = RESP;
      end
      RESP: begin
        // The request is still visible here; it is already served, so ignore it.
        ld_valid  = !mem_we;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request latch: memory-side outputs are registered so they stay stable through BUSY
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      lat_lo    <= '0;
      lat_func3 <= '0;
    end else if (accept) begin
      mem_req   <= 1'b1;
      mem_we    <= req_write;
      mem_addr  <= req_addr[DM_ADDRESS-1:2];
      mem_be    <= st_be;
      mem_wdata <= st_wdata;
      lat_lo    <= req_addr[1:0];
      lat_func3 <= req_func3;
    end else if (done) begin
      mem_req <= 1'b0;
    end
  end

  // Load result: captured on ack, held until the next load completes
  always_ff @(posedge clk) begin
    if (reset)                ld_data <= '0;
    else if (done && !mem_we) ld_data <= ld_ext;
  end

  // Saturating count of cycles spent waiting on the memory
  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= '0;
    else if ((state == BUSY) && !mem_ack && (wait_cnt != {CNT_W{1'b1}}))
      wait_cnt <= wait_cnt + 1'b1;
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: drives EX/MEM requests, models a memory
// with programmable ack delay, and checks against hand-computed values.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_read, req_write;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_func3;
  logic        stall, ld_valid, acc_err, mem_req, mem_we;
  logic [31:0] ld_data, mem_wdata, mem_rdata;
  logic [6:0]  mem_addr;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [15:0] wait_cnt;

  int total = 0;
  int bad   = 0;

  mem_stage_lsu #(.DM_ADDRESS(9), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_func3(req_func3),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data), .acc_err(acc_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One access: request held while stalled and through RESP, then dropped.
  // Ack arrives in BUSY cycle number dly (0 = first BUSY cycle).
  task automatic run_acc(input logic rd, input logic wr, input logic [8:0] a,
                         input logic [31:0] wd, input logic [2:0] f3,
                         input int dly, input logic [31:0] rdat,
                         output int stl, output logic [31:0] maddr,
                         output logic [3:0] be, output logic [31:0] mwd,
                         output logic we, output logic lv,
                         output logic [31:0] ld, output logic ok);
    req_read = rd; req_write = wr; req_addr = a; req_wdata = wd; req_func3 = f3;
    mem_ack = 1'b0;
    stl = 0; ok = 1'b1; lv = 1'b0; ld = '0;
    maddr = '0; be = '0; mwd = '0; we = 1'b0;
    @(negedge clk);
    stl += int'(stall);
    if (mem_req || ld_valid) ok = 1'b0;
    cyc();
    for (int i = 0; i <= dly; i++) begin
      mem_ack   = (i == dly);
      mem_rdata = (i == dly) ? rdat : 32'hDEAD_BEEF;
      @(negedge clk);
      stl += int'(stall);
      if (!mem_req || ld_valid) ok = 1'b0;
      if (i == 0) begin
        maddr = 32'(mem_addr); be = mem_be; mwd = mem_wdata; we = mem_we;
      end else if (32'(mem_addr) !== maddr || mem_be !== be ||
                   mem_wdata !== mwd || mem_we !== we) begin
        ok = 1'b0;
      end
      cyc();
    end
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    stl += int'(stall);
    lv = ld_valid; ld = ld_data;
    if (mem_req) ok = 1'b0;
    cyc();
    req_read = 1'b0; req_write = 1'b0;
    @(negedge clk);
    if (mem_req || ld_valid || stall) ok = 1'b0;
    cyc();
  endtask

  // Illegal request presented for one cycle, then withdrawn.
  task automatic run_ill(input string tag, input logic rd, input logic wr,
                         input logic [8:0] a, input logic [2:0] f3);
    req_read = rd; req_write = wr; req_addr = a; req_wdata = 32'h5555_5555; req_func3 = f3;
    @(negedge clk);
    chk({tag, "_err"}, 32'(acc_err), 32'd1);
    chk({tag, "_stall_req"}, {30'd0, stall, mem_req}, 32'd0);
    cyc();
    req_read = 1'b0; req_write = 1'b0;
    @(negedge clk);
    chk({tag, "_after"}, {29'd0, acc_err, stall, mem_req}, 32'd0);
    cyc();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {26'd0, stall, ld_valid, acc_err, mem_req, mem_we, 1'b0}, 32'd0);
    chk({tag, "_ld_data"}, ld_data, 32'd0);
    chk({tag, "_addr_be"}, {21'd0, mem_addr, mem_be}, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_wait"}, 32'(wait_cnt), 32'd0);
  endtask

  initial begin
    int          stl;
    logic [31:0] ma, wdo, ld;
    logic [3:0]  be;
    logic        we, lv, ok;

    reset = 1'b1; req_read = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_func3 = '0; mem_ack = 1'b0; mem_rdata = '0;
    cyc(); cyc();
    @(negedge clk);
    chk_all_zero("reset");
    cyc();
    reset = 1'b0;
    cyc();

    // LW, zero-wait
    run_acc(1'b1, 1'b0, 9'h010, 32'h0, F3_W, 0, 32'h8001_7F02, stl, ma, be, wdo, we, lv, ld, ok);
    chk("lw_stall", 32'(stl), 32'd2);
    chk("lw_addr", ma, 32'h04);
    chk("lw_be", 32'(be), 32'hF);
    chk("lw_we", 32'(we), 32'd0);
    chk("lw_valid", 32'(lv), 32'd1);
    chk("lw_data", ld, 32'h8001_7F02);
    chk("lw_proto", 32'(ok), 32'd1);

    // Sub-word loads on 0x80FF_0000
    run_acc(1'b1, 1'b0, 9'h013, 32'h0, F3_B, 0, 32'h80FF_0000, stl, ma, be, wdo, we, lv, ld, ok);
    chk("lb_data", ld, 32'hFFFF_FF80);
    chk("lb_addr_be", {ma[27:0], be}, {28'h4, 4'b1000});
    chk("lb_valid", 32'(lv), 32'd1);
    run_acc(1'b1, 1'b0, 9'h013, 32'h0, F3_BU, 0, 32'h80FF_0000, stl, ma, be, wdo, we, lv, ld, ok);
    chk("lbu_data", ld, 32'h0000_0080);
    run_acc(1'b1, 1'b0, 9'h012, 32'h0, F3_H, 0, 32'h80FF_0000, stl, ma, be, wdo, we, lv, ld, ok);
    chk("lh_data", ld, 32'hFFFF_80FF);
    chk("lh_be", 32'(be), 32'hC);
    run_acc(1'b1, 1'b0, 9'h012, 32'h0, F3_HU, 0, 32'h80FF_0000, stl, ma, be, wdo, we, lv, ld, ok);
    chk("lhu_data", ld, 32'h0000_80FF);
    chk("lhu_proto", 32'(ok), 32'd1);

    // Stores
    run_acc(1'b0, 1'b1, 9'h021, 32'h1234_56AB, F3_B, 0, 32'h0, stl, ma, be, wdo, we, lv, ld, ok);
    chk("sb_be", 32'(be), 32'b0010);
    chk("sb_wdata", wdo, 32'hABAB_ABAB);
    chk("sb_addr_we", {ma[30:0], we}, {31'h08, 1'b1});
    chk("sb_valid", 32'(lv), 32'd0);
    chk("sb_stall", 32'(stl), 32'd2);
    run_acc(1'b0, 1'b1, 9'h022, 32'hFFFF_1234, F3_H, 0, 32'h0, stl, ma, be, wdo, we, lv, ld, ok);
    chk("sh_be", 32'(be), 32'b1100);
    chk("sh_wdata", wdo, 32'h1234_1234);
    chk("sh_valid", 32'(lv), 32'd0);
    chk("sh_proto", 32'(ok), 32'd1);
    chk("ld_hold", ld_data, 32'h0000_80FF);

    // Read and write together is a write
    run_acc(1'b1, 1'b1, 9'h030, 32'hCAFE_F00D, F3_W, 0, 32'h0, stl, ma, be, wdo, we, lv, ld, ok);
    chk("rw_we_be", {27'd0, we, be}, {27'd0, 1'b1, 4'hF});
    chk("rw_wdata", wdo, 32'hCAFE_F00D);
    chk("rw_valid", 32'(lv), 32'd0);

    // Illegal accesses
    run_ill("ill_lw", 1'b1, 1'b0, 9'h002, F3_W);
    run_ill("ill_sh", 1'b0, 1'b1, 9'h005, F3_H);
    run_ill("ill_lf3", 1'b1, 1'b0, 9'h000, 3'd3);
    run_ill("ill_sf3", 1'b0, 1'b1, 9'h000, 3'd4);
    chk("ill_ld_hold", ld_data, 32'h0000_80FF);
    chk("ill_wait", 32'(wait_cnt), 32'd0);

    // Ack in the fifth BUSY cycle
    run_acc(1'b1, 1'b0, 9'h1FC, 32'h0, F3_W, 4, 32'h0BAD_F00D, stl, ma, be, wdo, we, lv, ld, ok);
    chk("dly_stall", 32'(stl), 32'd6);
    chk("dly_addr", ma, 32'h7F);
    chk("dly_proto", 32'(ok), 32'd1);
    chk("dly_data", ld, 32'h0BAD_F00D);
    chk("dly_wait", 32'(wait_cnt), 32'd4);

    // Reset in the second BUSY cycle, ack the cycle after
    req_read = 1'b1; req_write = 1'b0; req_addr = 9'h040; req_func3 = F3_W; mem_ack = 1'b0;
    @(negedge clk); cyc();
    @(negedge clk);
    chk("rb_busy", 32'(mem_req), 32'd1);
    cyc();
    reset = 1'b1;
    @(negedge clk); cyc();
    reset = 1'b0; req_read = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA;
    @(negedge clk);
    chk_all_zero("rb_out");
    cyc();
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("rb_ack_ign", {29'd0, ld_valid, mem_req, stall}, 32'd0);
    chk("rb_ld_data", ld_data, 32'd0);
    cyc();

    // Normal load after reset, one wait cycle
    run_acc(1'b1, 1'b0, 9'h0FC, 32'h0, F3_W, 1, 32'h1357_9BDF, stl, ma, be, wdo, we, lv, ld, ok);
    chk("post_stall", 32'(stl), 32'd3);
    chk("post_addr", ma, 32'h3F);
    chk("post_data", ld, 32'h1357_9BDF);
    chk("post_valid", 32'(lv), 32'd1);
    chk("post_wait", 32'(wait_cnt), 32'd1);
    chk("post_proto", 32'(ok), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
